seg_scan_multi: RTL and testbench

SEG_SCAN_MULTI -- requirements
Module: seg_scan_multi

---
 rtl/seg_scan_pkg.sv | 19 +
 rtl/seg_scan_multi_hex7seg.sv | 11 +
 rtl/seg_scan_multi.sv | 109 ++++++++++
 tb/tb_seg_scan_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph table,
// blank pattern and brightness full-scale code.
package seg_scan_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0]       BRIGHT_FULL = 4'hF;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
    localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_multi_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_multi.sv
// Time-multiplexed hex display driver with tear-free shadow frames,
// leading-zero blanking and PWM brightness.
module seg_scan_multi
    import seg_scan_pkg::*;
#(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned DIV_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      div_value,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [DIV_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            pwm_cnt;
    logic [4*N_DIGITS-1:0] sh_din;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_en;
    logic                  sh_blank;

    logic [DIV_W-1:0]      div_last_c;
    logic                  tick_c;
    logic                  wrap_c;
    logic [N_DIGITS-1:0]   lz_mask_c;
    logic [NIB_W-1:0]      nibble_c;
    logic [SEG_W-1:0]      glyph_c;
    logic                  lit_c;

    // A divider of 0 behaves as 1; ">=" lets a shrunken divider fire at once
    assign div_last_c = (div_value == '0) ? '0 : div_value - DIV_W'(1);
    assign tick_c     = (cnt >= div_last_c);
    assign wrap_c     = tick_c && (idx == IDX_LAST);

    // Digit k is blanked when it and every higher shadow nibble are zero
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        lz_mask_c   = '0;
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            zeros_above = zeros_above && (sh_din[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_mask_c[k] = sh_blank && zeros_above;
            end
        end
    end

    assign nibble_c = sh_din[{idx, 2'b00} +: NIB_W];
    assign lit_c    = sh_en[idx] && !lz_mask_c[idx] &&
                      ((pwm_cnt < brightness) || (brightness == BRIGHT_FULL));

    hex7seg u_hex7seg (
        .nibble (nibble_c),
        .seg_c  (glyph_c)
    );

    // Prescaler, digit index, PWM phase and frame shadow registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            sh_din      <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
            sh_blank    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt + 4'd1;
            cnt         <= tick_c ? '0 : cnt + DIV_W'(1);
            frame_start <= wrap_c;
            if (tick_c) begin
                idx <= wrap_c ? '0 : idx + IDX_W'(1);
            end
            if (wrap_c) begin
                sh_din   <= din;
                sh_dp    <= dp;
                sh_en    <= digit_en;
                sh_blank <= blank_lz;
            end
        end
    end

    // Registered pin drivers; at most one anode is ever pulled low
    always_ff @(posedge clk) begin
        if (!rst) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= lit_c ? ~(N_DIGITS'(1) << idx) : '1;
            seg  <= lit_c ? glyph_c : SEG_BLANK;
            dp_n <= lit_c ? ~sh_dp[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Scoreboard bench for seg_scan_multi: expected per-slot outputs are queued
// per frame and popped as each digit slot is displayed.
module tb_seg_scan_multi;

    localparam int unsigned N     = 8;
    localparam int unsigned DIV_W = 32;

    logic             clk;
    logic             rst;
    logic [DIV_W-1:0] div_value;
    logic [4*N-1:0]   din;
    logic [N-1:0]     dp;
    logic [N-1:0]     digit_en;
    logic             blank_lz;
    logic [3:0]       brightness;
    logic [N-1:0]     an;
    logic [6:0]       seg;
    logic             dp_n;
    logic             frame_start;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 0;
    bit   fs_prev  = 0;

    seg_scan_multi #(.N_DIGITS(N), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_value   (div_value),
        .din         (din),
        .dp          (dp),
        .digit_en    (digit_en),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Glyphs written active-high (gfedcba) and inverted for the pins
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] hi;
        case (v)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    task automatic expect_frame(input logic [31:0] d, input logic [7:0] p,
                                input logic [7:0] e, input bit blank);
        int   top;
        exp_t x;
        top = -1;
        for (int k = 0; k < 8; k++) if (d[4*k +: 4] != 4'h0) top = k;
        for (int k = 0; k < 8; k++) begin
            bit dark;
            dark = !e[k] || (blank && k > 0 && k > top);
            x.an   = dark ? 8'hFF : ~(8'h01 << k);
            x.seg  = dark ? 7'h7F : glyph(d[4*k +: 4]);
            x.dp_n = dark ? 1'b1 : ~p[k];
            sb.push_back(x);
        end
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < budget);
        if (!frame_start) check("frame_timeout", 1, 0);
    endtask

    // Sample each slot in its middle (div_value = 4); optionally swap din mid-frame
    task automatic check_frame(input int swap_k, input logic [31:0] swap_din);
        exp_t x;
        wait_frame(400);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                x = sb.pop_front();
                check($sformatf("an_d%0d", k), 32'(an), 32'(x.an));
                check($sformatf("seg_d%0d", k), 32'(seg), 32'(x.seg));
                check($sformatf("dpn_d%0d", k), 32'(dp_n), 32'(x.dp_n));
            end
            if (k == swap_k) din = swap_din;
        end
    endtask

    task automatic frame_period(output int n);
        wait_frame(400);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 400);
    endtask

    // Anode one-hot-or-none and single-cycle frame_start on every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            check("an_onehot", 32'($countones(~an) <= 1), 1);
            check("fs_pulse", 32'(fs_prev && frame_start), 0);
            fs_prev = frame_start;
        end
    end

    initial begin
        int n_lit;
        int per;
        rst        = 1'b0;
        div_value  = 32'd4;
        din        = 32'h1234ABCD;
        dp         = 8'h81;
        digit_en   = 8'hFF;
        blank_lz   = 1'b0;
        brightness = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dpn", 32'(dp_n), 1);
        check("rst_fs", 32'(frame_start), 0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Shadows are still cleared during the first frame
        repeat (6) @(negedge clk);
        check("dark_first", 32'(an), 32'hFF);

        expect_frame(32'h1234ABCD, 8'h81, 8'hFF, 1'b0);
        check_frame(-1, '0);

        din = 32'h00000450; dp = 8'h09; blank_lz = 1'b1;
        expect_frame(din, dp, digit_en, blank_lz);
        check_frame(-1, '0);

        din = 32'h0; dp = 8'h00;
        expect_frame(din, dp, digit_en, blank_lz);
        check_frame(-1, '0);

        din = 32'h89EF0567; dp = 8'hFF; digit_en = 8'hA5;
        expect_frame(din, dp, digit_en, blank_lz);
        check_frame(-1, '0);

        // Mid-frame din change must not tear the frame on display
        din = 32'h11111111; dp = 8'h00; digit_en = 8'hFF; blank_lz = 1'b0;
        expect_frame(32'h11111111, 8'h00, 8'hFF, 1'b0);
        check_frame(3, 32'h22222222);
        expect_frame(32'h22222222, 8'h00, 8'hFF, 1'b0);
        check_frame(-1, '0);

        // PWM: any 16 consecutive cycles hold exactly 4 lit cycles
        div_value = 32'd64; brightness = 4'd4;
        wait_frame(2000);
        wait_frame(2000);
        repeat (2) @(negedge clk);
        n_lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an != 8'hFF) begin
                n_lit++;
                check("pwm_an", 32'(an), 32'hFE);
            end
        end
        check("pwm_duty", 32'(n_lit), 4);

        brightness = 4'd0;
        repeat (2) @(negedge clk);
        n_lit = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an != 8'hFF) n_lit++;
        end
        check("bright0_dark", 32'(n_lit), 0);
        wait_frame(2000);
        check("bright0_adv", 32'(frame_start), 1);

        brightness = 4'hF;
        div_value = 32'd0;
        frame_period(per);
        check("div0_period", 32'(per), 8);
        div_value = 32'd1;
        frame_period(per);
        check("div1_period", 32'(per), 8);
        div_value = 32'd3;
        frame_period(per);
        check("div3_period", 32'(per), 24);

        // Reset pulse mid-slot
        div_value = 32'd4; din = 32'h1234ABCD; dp = 8'h81;
        wait_frame(400);
        wait_frame(400);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_an", 32'(an), 32'hFF);
        check("mrst_seg", 32'(seg), 32'h7F);
        check("mrst_dpn", 32'(dp_n), 1);
        check("mrst_fs", 32'(frame_start), 0);
        rst = 1'b1;
        per = 0;
        do begin
            @(negedge clk);
            per++;
            if (per == 3) check("mrst_dark", 32'(an), 32'hFF);
        end while (!frame_start && per < 400);
        check("mrst_first_fs", 32'(per), 32);
        expect_frame(32'h1234ABCD, 8'h81, 8'hFF, 1'b0);
        check_frame(-1, '0);

        check("sb_drained", 32'(sb.size()), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
